// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO controller.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH_DEFAULT = 4;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_ctrl.sv
// Pointer/flag controller for a FWFT FIFO built around a combinational-read RAM.
// Optional registered occupancy output enabled by defining FIFO_FWFT_LEVEL_EN.
module fifo_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  ovf,
  output logic                  unf
`ifdef FIFO_FWFT_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam int AW = ADDR_WIDTH;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_inc_s;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          almost_full_q, almost_full_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_s, pop_s;

  // Request acceptance; a push into a full FIFO is allowed when a pop frees the slot.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (reset_n) begin
      push_s = wr & (~full_q | rd);
      pop_s  = rd & ~empty_q;
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  // Next-state pointers, flags derived from those pointers, and sticky errors.
  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    wptr_inc_s    = '0;
    full_d        = 1'b0;
    empty_d       = 1'b1;
    almost_full_d = 1'b0;
    ovf_d         = ovf_q;
    unf_d         = unf_q;

    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[PW-1] != rptr_d[PW-1]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

    // One more word would make it full: compare without a subtractor.
    wptr_inc_s    = wptr_d + PW'(1);
    almost_full_d = full_d | (wptr_inc_s == {~rptr_d[PW-1], rptr_d[AW-1:0]});

    if (wr & full_q & ~rd) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rd & empty_q) begin
      unf_d = 1'b1;
    end else if (err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almost_full_q <= almost_full_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

`ifdef FIFO_FWFT_LEVEL_EN
  logic [PW-1:0] level_q, level_d;

  // Occupancy follows the next-state pointers so it updates with them.
  always_comb begin
    level_d = wptr_d - rptr_d;
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

  assign wr_en       = push_s;
  assign wr_addr     = wptr_q[AW-1:0];
  assign rd_addr     = rptr_q[AW-1:0];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = almost_full_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;

endmodule

// File: doc/fifo_fwft_ctrl.md
# fifo_fwft_ctrl

- Pointer and flag controller that pairs with the dual-port `ram` to form the first-word-fall-through FIFO in the range-sensor controller.
- Turns producer `wr` and consumer `rd` requests into RAM `wr_en`/`wr_addr`/`rd_addr`, and keeps `full`/`empty` status.
- Because the RAM read is combinational, the head word is already on the RAM read data whenever `empty` is low. A read only advances the pointer.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width. Depth is 2**ADDR_WIDTH and every slot is usable.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `wr` input 1: producer push request.
- `rd` input 1: consumer pop request; the head word is consumed at this edge.
- `err_clr` input 1: clears the sticky error flags.
- `wr_en` output 1: RAM write enable; high when a push is accepted. Combinational.
- `wr_addr` output ADDR_WIDTH: RAM write address; the lower bits of the write pointer.
- `rd_addr` output ADDR_WIDTH: RAM read address; the lower bits of the read pointer.
- `full` output 1: registered; the FIFO holds 2**ADDR_WIDTH words.
- `empty` output 1: registered; the FIFO holds 0 words and RAM read data is invalid.
- `almost_full` output 1: registered; occupancy is at least 2**ADDR_WIDTH-1.
- `ovf` output 1: sticky flag; a `wr` was rejected while full.
- `unf` output 1: sticky flag; a `rd` was rejected while empty.
- `level` output ADDR_WIDTH+1: occupancy 0..2**ADDR_WIDTH. Present only with `FIFO_FWFT_LEVEL_EN`.

## Operation
- **Pointers.** `wptr` and `rptr` are ADDR_WIDTH+1 bits wide and increment modulo 2**(ADDR_WIDTH+1).
  - MSB is the wrap bit.
  - Empty when `wptr == rptr`.
  - Full when the MSBs differ and the lower bits are equal.
- **Accept rules:**
  - `push = wr & (~full | rd)`.
  - `pop = rd & ~empty`.
  - `wr & rd` while full: both are accepted. The write lands in the slot being vacated. The consumer still sees the old head, because the read is combinational before the edge.
  - `wr & rd` while empty: the push is accepted and the pop is ignored. `unf` is set.
- **Wiring:** `wr_en = push`. `wptr` increments on push; `rptr` increments on pop.
- **Flags** are computed from the next-state pointers and registered, so they are valid in the same cycle as the pointers.
  - Occupancy = `wptr - rptr`, taken modulo 2**(ADDR_WIDTH+1).
  - `almost_full` is high when occupancy is at least 2**ADDR_WIDTH-1.
- **Sticky errors:**
  - `ovf` sets on `wr & full & ~rd`.
  - `unf` sets on `rd & empty`.
  - `err_clr` clears both.
  - If a set condition and `err_clr` occur in the same cycle, the set wins.
- **Reset values:**
  - Pointers 0.
  - `empty`=1, `full`=0, `almost_full`=0.
  - `ovf`=0, `unf`=0, `level`=0.
  - `wr_en`=0 while `reset_n` is low; requests are ignored.
- **Reset mid-operation** discards all stored words. RAM contents are left as they are but become unreachable.

## Timing
- Push at edge N: `empty` falls after edge N. The written word is readable in cycle N+1. Write-to-visible latency is 1 cycle.
- Pop at edge N: `rd_addr` points to the next word after edge N. The consumer samples the data before the edge.
- A sustained push and pop every cycle gives 1 word/cycle with occupancy unchanged.
- Pointer wrap-around is seamless; there is no bubble at the address roll-over.
- `wr_en` is combinational from `wr`, `rd`, and the registered `full`. No other output is combinational.

## Configuration
- `FIFO_FWFT_LEVEL_EN` defined:
  - The `level` port exists.
  - `level` is registered and equals `wptr - rptr` (modulo 2**(ADDR_WIDTH+1)), updated with the pointers.
- `FIFO_FWFT_LEVEL_EN` undefined:
  - The `level` port is absent and no subtractor is built.
  - `almost_full` uses a dedicated compare and is unaffected.

## Structure
- Package `fifo_pkg` holds `FIFO_ADDR_WIDTH_DEFAULT` (= 4) and the pointer-width helper `function automatic int ptr_w(int aw)` (returns aw+1).
- No sub-modules. The FIFO top instantiates `fifo_fwft_ctrl` next to `ram`.

## Test plan
(All cases use ADDR_WIDTH=2, depth 4.)
- **Reset:** hold `reset_n`=0 for 3 cycles with `wr`=1 throughout.
  - Required: `empty`=1, `full`=0, `wr_en`=0.
  - Required after release: `wr_addr`=0, `rd_addr`=0.
- **Fill:** 4 pushes of 0xA0..0xA3.
  - Required: `almost_full` rises after the 3rd push; `full` rises after the 4th.
  - Then a 5th push: `ovf`=1, `wr_en`=0, `wr_addr` stays 0.
- **Drain:** 4 pops from full.
  - Required: the RAM read data sequence is 0xA0, 0xA1, 0xA2, 0xA3; `empty`=1 after the 4th.
  - Then a 5th pop: `unf`=1 and `rd_addr` unchanged.
- **Simultaneous while full:** `wr`=`rd`=1 with 0xB0.
  - Required: `full` stays 1, occupancy stays 4, the consumer sees the old head, and 0xB0 is stored.
- **Simultaneous while empty:** `wr`=`rd`=1.
  - Required: occupancy becomes 1, `empty`=0 next cycle, `unf`=1.
- **Wrap and config:** 10 push/pop pairs.
  - Required: `rd_addr` cycles 0,1,2,3,0,… and the data stays in order.
  - With `FIFO_FWFT_LEVEL_EN` defined, `level` tracks 0→4→0 exactly through the Fill and Drain cases.
